expr_reader: RTL and testbench

- Read-side counterpart of the token store `ds`. The keyboard path writes tokens into `ds`; this block reads them back out.
- On the eval pulse it walks the token memory from slot 0 and streams each token downstream over a valid/ready handshake, one token per accepted beat.
- It stops at the first empty slot or at the end of memory.
- It sits between `ds` and the evaluator, which is built later.

---
 rtl/calc_pkg.sv | 28 ++
 rtl/expr_slot_mux.sv | 41 ++++
 rtl/expr_reader.sv | 153 +++++++++++++++
 tb/tb_expr_reader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator token path (keyboard, store, reader, evaluator).
// Holds the reader FSM states, the token width, the empty-slot code and token codes.
// Token codes follow ASCII so the keyboard block can write key codes straight into the store.
package calc_pkg;

    localparam int TOKEN_W = 8;
    localparam int DEPTH   = 20;

    // A slot holding this value is unused and terminates the expression.
    localparam logic [TOKEN_W-1:0] EMPTY_CODE = 8'h00;

    // Digit tokens are TOK_DIGIT0 + value.
    localparam logic [TOKEN_W-1:0] TOK_DIGIT0 = 8'h30;
    localparam logic [TOKEN_W-1:0] TOK_ADD    = 8'h2B;
    localparam logic [TOKEN_W-1:0] TOK_SUB    = 8'h2D;
    localparam logic [TOKEN_W-1:0] TOK_MUL    = 8'h2A;
    localparam logic [TOKEN_W-1:0] TOK_DIV    = 8'h2F;
    localparam logic [TOKEN_W-1:0] TOK_LPAREN = 8'h28;
    localparam logic [TOKEN_W-1:0] TOK_RPAREN = 8'h29;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/expr_slot_mux.sv
// Combinational slot select from the flattened token store, with is-last lookahead.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the selected slot is consumed.
//
// Ports:
//   mem_flat  flattened store, slot i at [i*width +: width]
//   index     slot to select; an index of depth or more selects zero
//   slot      selected token
//   is_last   index is the final slot, or the following slot is EMPTY_CODE
module expr_slot_mux #(
    parameter int              depth      = 20,
    parameter int              width      = 8,
    parameter logic [width-1:0] EMPTY_CODE = '0,
    parameter int              IW         = $clog2(depth + 1)
) (
    input  logic [depth*width-1:0] mem_flat,
    input  logic [IW-1:0]          index,
    output logic [width-1:0]       slot,
    output logic                   is_last
);

    always_comb begin
        slot    = '0;
        is_last = 1'b0;
        for (int i = 0; i < depth; i++) begin
            if (index == IW'(i)) begin
                slot = mem_flat[i*width +: width];
            end
        end
        if (index == IW'(depth - 1)) begin
            is_last = 1'b1;
        end
        // Lookahead only exists below the top slot, so the loop stops one short.
        for (int i = 0; i < depth - 1; i++) begin
            if (index == IW'(i) && mem_flat[(i+1)*width +: width] == EMPTY_CODE) begin
                is_last = 1'b1;
            end
        end
    end

endmodule

// File: rtl/expr_reader.sv
// Walks the token store from slot 0 on start and streams tokens until an empty slot or the end.
// Latency: first tok_valid 2 cycles after start; one token per 2 cycles (LOAD/SEND alternate).
// Backpressure: tok_valid/tok_data/tok_last held stable in SEND until tok_ready accepts the beat.
//
// Ports:
//   clock, reset (sync, active-high), start (eval pulse), mem_flat (store, slot i at [i*width +: width])
//   tok_data/tok_valid/tok_ready/tok_last  downstream token stream
//   busy (walk in progress), done (end pulse), count (tokens sent, held), empty_expr (zero tokens)
// Option: define EXPR_READER_SNAPSHOT_EN to copy mem_flat on start and read from that copy.
module expr_reader #(
    parameter int               depth      = calc_pkg::DEPTH,
    parameter int               width      = calc_pkg::TOKEN_W,
    parameter logic [width-1:0] EMPTY_CODE = calc_pkg::EMPTY_CODE
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [depth*width-1:0]       mem_flat,
    output logic [width-1:0]             tok_data,
    output logic                         tok_valid,
    input  logic                         tok_ready,
    output logic                         tok_last,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic                         empty_expr
);
    import calc_pkg::*;

    localparam int IW = $clog2(depth + 1);

    state_t                 state;
    state_t                 state_nx;
    logic [IW-1:0]          index;
    logic [width-1:0]       slot;
    logic                   slot_last;
    logic [width-1:0]       data_q;
    logic                   last_q;
    logic [depth*width-1:0] src;

`ifdef EXPR_READER_SNAPSHOT_EN
    logic [depth*width-1:0] snap;

    // The store may be edited while we walk; the stream always reflects the store at start.
    always_ff @(posedge clock) begin
        if (reset) begin
            snap <= '0;
        end else if (state == IDLE && start) begin
            snap <= mem_flat;
        end
    end

    assign src = snap;
`else
    assign src = mem_flat;
`endif

    expr_slot_mux #(
        .depth      (depth),
        .width      (width),
        .EMPTY_CODE (EMPTY_CODE),
        .IW         (IW)
    ) u_slot_mux (
        .mem_flat (src),
        .index    (index),
        .slot     (slot),
        .is_last  (slot_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        tok_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (index == IW'(depth) || slot == EMPTY_CODE) begin
                    state_nx = FIN;
                end else begin
                    state_nx = SEND;
                end
            end
            SEND: begin
                busy      = 1'b1;
                tok_valid = 1'b1;
                if (tok_ready) begin
                    state_nx = last_q ? FIN : LOAD;
                end
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            index      <= '0;
            count      <= '0;
            empty_expr <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        index      <= '0;
                        count      <= '0;
                        empty_expr <= 1'b0;
                    end
                end
                LOAD: begin
                    if (state_nx == SEND) begin
                        data_q <= slot;
                        last_q <= slot_last;
                    end else begin
                        // Entering FIN from LOAD: valid in the same cycle as done.
                        // Entry from SEND always follows a beat, so empty_expr stays 0 there.
                        empty_expr <= (count == '0);
                    end
                end
                SEND: begin
                    if (tok_ready) begin
                        count <= count + 1'b1;
                        index <= index + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tok_data = data_q;
    // last_q is stale outside SEND, so only expose it alongside tok_valid.
    assign tok_last = last_q & tok_valid;

endmodule

// File: tb/tb_expr_reader.sv
// Randomized scoreboard bench for expr_reader.
// Stimulus pushes expected tokens and walk results; a negedge monitor pops and compares.
// Reference: the expression is the run of leading non-empty slots; the last of them is flagged.
module tb_expr_reader;

    localparam int DEPTH = 20;
    localparam int W     = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic [DEPTH*W-1:0] mem_flat;
    logic [W-1:0]       tok_data;
    logic               tok_valid;
    logic               tok_ready;
    logic               tok_last;
    logic               busy;
    logic               done;
    logic [CW-1:0]      count;
    logic               empty_expr;

    always #5 clock = ~clock;

    expr_reader dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .mem_flat   (mem_flat),
        .tok_data   (tok_data),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_last   (tok_last),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .empty_expr (empty_expr)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } tok_t;

    int         checks   = 0;
    int         failures = 0;
    tok_t       exp_tok[$];
    int         exp_done[$];
    logic [W-1:0] mem [DEPTH];
    int         beats;
    bit         prev_stall;
    logic [W-1:0] prev_data;
    tok_t       mon_t;
    int         mon_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    task automatic pack_mem();
        for (int i = 0; i < DEPTH; i++) mem_flat[i*W +: W] = mem[i];
    endtask

    // Reference: count the leading non-empty slots, then emit them with the final one flagged.
    task automatic expect_walk(output int n);
        n = 0;
        while (n < DEPTH && mem[n] != 8'h00) n++;
        for (int k = 0; k < n; k++) begin
            tok_t t;
            t.d = mem[k];
            t.l = (k == n - 1);
            exp_tok.push_back(t);
        end
        exp_done.push_back(n);
    endtask

    // Monitor: inputs change at posedge+2, so at negedge a valid&&ready means a beat at the next edge.
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", tok_valid, 1);
                chk("hold_data", tok_data, prev_data);
            end
            if (!tok_valid) chk("last_without_valid", tok_last, 0);
            if (tok_valid && tok_ready) begin
                if (exp_tok.size() == 0) begin
                    flag("unexpected_beat");
                end else begin
                    mon_t = exp_tok.pop_front();
                    chk("tok_data", tok_data, mon_t.d);
                    chk("tok_last", tok_last, mon_t.l);
                end
                beats++;
            end
            prev_stall = tok_valid && !tok_ready;
            prev_data  = tok_data;
            if (done) begin
                if (exp_done.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    mon_n = exp_done.pop_front();
                    chk("done_count", count, mon_n);
                    chk("done_empty_expr", empty_expr, (mon_n == 0));
                    chk("done_busy_low", busy, 0);
                end
            end
        end
    end

    // mode 0: ready always high (latency checked); 1: random ready; 2: 5-cycle stall on beat 2.
    task automatic walk(input int mode, input bit second_start);
        int  n;
        int  cyc;
        int  first_v;
        int  stall_left;
        bit  seen;
        pack_mem();
        expect_walk(n);
        beats      = 0;
        cyc        = 0;
        first_v    = -1;
        stall_left = 5;
        seen       = 1'b0;
        @(posedge clock);
        #2;
        start     = 1'b1;
        tok_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clock);
        while (!seen && cyc < 400) begin
            @(posedge clock);
            #2;
            start = second_start && (cyc == 2);
            if (mode == 1) begin
                tok_ready = 1'($urandom_range(0, 1));
            end else if (mode == 2 && beats == 1 && tok_valid && stall_left > 0) begin
                tok_ready = 1'b0;
                stall_left--;
            end else begin
                tok_ready = 1'b1;
            end
            @(negedge clock);
            cyc++;
            if (tok_valid && first_v < 0) first_v = cyc;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) flag("done_timeout");
        if (mode == 0) begin
            chk("done_latency", cyc, (n == 0) ? 2 : 2 * n + 1);
            if (n > 0) chk("first_valid_latency", first_v, 2);
            else       chk("no_valid_when_empty", first_v, -1);
        end
        if (mode == 2) chk("stall_beats", beats, n);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        reset     = 1'b1;
        start     = 1'b0;
        tok_ready = 1'b0;
        mem_flat  = '0;
        beats     = 0;
        prev_stall = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_tok_data", tok_data, 0);
        chk("rst_tok_valid", tok_valid, 0);
        chk("rst_tok_last", tok_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_empty_expr", empty_expr, 0);

        // "1+2"
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        mem[0] = 8'h31; mem[1] = 8'h2B; mem[2] = 8'h32;
        walk(0, 1'b0);

        // empty expression
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        walk(0, 1'b0);

        // full store
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(1, 255));
        walk(0, 1'b0);

        // stall on second beat, then a redundant start while busy
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        mem[0] = 8'h37; mem[1] = 8'h2A; mem[2] = 8'h39;
        walk(2, 1'b0);
        mem[3] = 8'h2D;
        walk(0, 1'b1);

        // random lengths with non-empty garbage beyond the terminator
        for (int r = 0; r < 30; r++) begin
            len = $urandom_range(0, DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                if (i < len)       mem[i] = 8'($urandom_range(1, 255));
                else if (i == len) mem[i] = 8'h00;
                else               mem[i] = 8'($urandom_range(0, 255));
            end
            walk((r % 4 == 0) ? 0 : 1, 1'b0);
        end

        // reset while a token is stalled in SEND
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        for (int i = 0; i < 5; i++) mem[i] = 8'h30 + 8'(i);
        pack_mem();
        @(posedge clock);
        #2;
        start     = 1'b1;
        tok_ready = 1'b0;
        @(posedge clock);
        #2;
        start = 1'b0;
        len = 0;
        while (!tok_valid && len < 10) begin
            @(posedge clock);
            #2;
            len++;
        end
        chk("pre_reset_valid", tok_valid, 1);
        reset = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_tok_valid", tok_valid, 0);
        chk("mid_rst_tok_data", tok_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_done", done, 0);
        tok_ready = 1'b1;
        repeat (5) @(negedge clock);
        chk("mid_rst_still_idle", busy, 0);

        // start coincident with reset is dropped
        @(posedge clock);
        #2;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk("rst_start_busy", busy, 0);
        @(negedge clock);
        chk("rst_start_busy_2", busy, 0);
        chk("rst_start_valid", tok_valid, 0);
        repeat (3) @(negedge clock);

        chk("tok_queue_drained", exp_tok.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
